timebase_ctrl: RTL and testbench
================================

TIMEBASE_CTRL -- requirements
Module: timebase_ctrl

Interface
REQ-001 The block SHALL have parameter CLK_FREQ, default 50000000, giving the input clock frequency in Hz; it SHALL be a multiple of 1000 and at least 2000.
REQ-002 The block SHALL derive PRE_DIV = CLK_FREQ/1000, the prescaler modulus, with the prescaler width sized to hold PRE_DIV-1.
REQ-003 The block SHALL have one clock and an asynchronous, active-high reset: CLK_50 in 1, system clock, all logic on its rising edge.
REQ-004 The block SHALL have RST in 1, asynchronous active-high reset.
REQ-005 The block SHALL have start in 1, single-cycle synchronous command to enter RUN.
REQ-006 The block SHALL have stop in 1, single-cycle synchronous command to enter STOP.
REQ-007 The block SHALL have set in 1, single-cycle synchronous command that toggles time-set mode.
REQ-008 The block SHALL have up_key in 1, level input, already debounced and synchronous, requesting fast advance in SET.
REQ-009 The block SHALL have tick_1k, tick_500, tick_4, tick_2 and tick_1 out 1 each, single-cycle enable pulses.
REQ-010 The block SHALL have adv out 1, a single-cycle advance pulse to the calendar counter.
REQ-011 The block SHALL have blink out 1, a 2 Hz square wave with 50% duty.
REQ-012 The block SHALL have state out 2, giving the current FSM state: STOP=0, RUN=1, SET=2, with 3 unused.

Function
REQ-013 The prescaler SHALL count 0..PRE_DIV-1 and wrap; the "wrap edge" is the edge at which it holds PRE_DIV-1.
REQ-014 ms_cnt SHALL count 0..999 and SHALL increment only at wrap edges, wrapping 999->0.
REQ-015 All tick outputs SHALL be registered, and each is high for exactly one cycle following a wrap edge, evaluated on the pre-increment ms_cnt:
- tick_1k on every wrap edge;
- tick_500 when ms_cnt is odd;
- tick_4 when ms_cnt mod 250 = 249;
- tick_2 when ms_cnt mod 500 = 499;
- tick_1 when ms_cnt = 999.
REQ-016 Coincident ticks SHALL assert in the same cycle, e.g. at ms_cnt=999 all five pulse together.
REQ-017 The prescaler, ms_cnt and ticks SHALL free-run in every state, so display scanning never stops.
REQ-018 blink SHALL toggle in the cycle after each tick_4 pulse.
REQ-019 The FSM SHALL apply command priority stop > set > start when several commands are high in one cycle.
REQ-020 FSM transitions in STOP SHALL be: start->RUN, set->SET, otherwise hold.
REQ-021 FSM transitions in RUN SHALL be: stop->STOP, set->SET, start ignored.
REQ-022 FSM transitions in SET SHALL be: stop->STOP, set->RUN, start ignored.
REQ-023 On every transition into RUN, the prescaler and ms_cnt SHALL be cleared to 0 at that edge.
REQ-024 No tick SHALL be generated at the clearing edge, so the first adv after entering RUN occurs exactly 1000*PRE_DIV cycles later.
REQ-025 adv SHALL be registered and based on the pre-transition state:
- RUN: adv = tick_1 condition;
- SET: adv = tick_4 condition AND up_key;
- STOP: adv = 0.
REQ-026 A command that does not change state (e.g. start in RUN) SHALL NOT clear any counter.
REQ-027 state SHALL update at the edge the command is sampled, i.e. one cycle latency from command to state.

Reset
REQ-028 While RST is high, all outputs SHALL be 0: all ticks, adv, blink, and state=STOP.
REQ-029 While RST is high, the prescaler and ms_cnt SHALL be 0.
REQ-030 Assertion of RST at any time SHALL take effect immediately, without a clock.
REQ-031 RST asserted mid-operation SHALL discard all progress.
REQ-032 After RST deasserts, the first tick_1k SHALL occur PRE_DIV cycles later, and the FSM SHALL remain in STOP until commanded.

Verification
REQ-033 With CLK_FREQ=4000 (PRE_DIV=4), after reset the bench SHALL see: tick_1k every 4 cycles; tick_500 every 8; tick_4 every 1000; tick_2 every 2000; tick_1 every 4000; blink period 2000 cycles.
REQ-034 With CLK_FREQ=4000, holding STOP for 10000 cycles SHALL give adv=0 throughout while tick_1 pulses twice.
REQ-035 With CLK_FREQ=4000, a start pulse SHALL give state=1 on the next cycle, and the first adv exactly 4000 cycles after the start edge, then every 4000.
REQ-036 With CLK_FREQ=4000 in SET with up_key=1, the bench SHALL see adv every 1000 cycles; with up_key=0, no adv; a set pulse then gives RUN and the next adv 4000 cycles later.
REQ-037 With CLK_FREQ=4000, start, stop and set all high in one cycle from RUN SHALL give state=STOP, with counters not cleared.
REQ-038 With CLK_FREQ=4000, RST pulsed mid-second in RUN SHALL immediately give all outputs 0 and state=0, and the first tick_1k 4 cycles after release.

Source files
------------

// File: rtl/timebase_ctrl.sv
// Timebase and run/stop/set controller: divides the system clock to a 1 kHz
// prescale, derives enable ticks and a blink wave, and paces the calendar via adv.
module timebase_ctrl #(
    parameter int CLK_FREQ = 50000000
) (
    input  logic       CLK_50,
    input  logic       RST,
    input  logic       start,
    input  logic       stop,
    input  logic       set,
    input  logic       up_key,
    output logic       tick_1k,
    output logic       tick_500,
    output logic       tick_4,
    output logic       tick_2,
    output logic       tick_1,
    output logic       adv,
    output logic       blink,
    output logic [1:0] state
);

    localparam int PRE_DIV = CLK_FREQ / 1000;
    localparam int PRE_W   = (PRE_DIV > 1) ? $clog2(PRE_DIV) : 1;
    localparam logic [PRE_W-1:0] PRE_MAX = PRE_W'(PRE_DIV - 1);

    typedef enum logic [1:0] {
        ST_STOP = 2'd0,
        ST_RUN  = 2'd1,
        ST_SET  = 2'd2
    } state_t;

    state_t           cur_state;
    state_t           next_state;
    logic [PRE_W-1:0] pre_cnt;
    logic [9:0]       ms_cnt;
    logic             wrap;
    logic             quarter_end;
    logic             half_end;
    logic             second_end;
    logic             enter_run;
    logic             adv_cond;

    assign wrap        = (pre_cnt == PRE_MAX);
    assign second_end  = (ms_cnt == 10'd999);
    assign half_end    = (ms_cnt == 10'd499) || second_end;
    assign quarter_end = (ms_cnt == 10'd249) || (ms_cnt == 10'd749) || half_end;
    assign state       = cur_state;

    // Command priority is stop > set > start in every state.
    always_comb begin
        next_state = cur_state;
        case (cur_state)
            ST_STOP: begin
                if (stop)       next_state = ST_STOP;
                else if (set)   next_state = ST_SET;
                else if (start) next_state = ST_RUN;
            end
            ST_RUN: begin
                if (stop)       next_state = ST_STOP;
                else if (set)   next_state = ST_SET;
            end
            ST_SET: begin
                if (stop)       next_state = ST_STOP;
                else if (set)   next_state = ST_RUN;
            end
            default:            next_state = ST_STOP;
        endcase
    end

    assign enter_run = (next_state == ST_RUN) && (cur_state != ST_RUN);

    always_comb begin
        adv_cond = 1'b0;
        case (cur_state)
            ST_RUN:  adv_cond = wrap && second_end;
            ST_SET:  adv_cond = wrap && quarter_end && up_key;
            default: adv_cond = 1'b0;
        endcase
    end

    always_ff @(posedge CLK_50 or posedge RST) begin
        if (RST) cur_state <= ST_STOP;
        else     cur_state <= next_state;
    end

    // Entering RUN restarts the second from zero and swallows any tick due at
    // that edge, so the first adv lands a full second after the command.
    always_ff @(posedge CLK_50 or posedge RST) begin
        if (RST) begin
            pre_cnt  <= '0;
            ms_cnt   <= '0;
            tick_1k  <= 1'b0;
            tick_500 <= 1'b0;
            tick_4   <= 1'b0;
            tick_2   <= 1'b0;
            tick_1   <= 1'b0;
            adv      <= 1'b0;
        end else if (enter_run) begin
            pre_cnt  <= '0;
            ms_cnt   <= '0;
            tick_1k  <= 1'b0;
            tick_500 <= 1'b0;
            tick_4   <= 1'b0;
            tick_2   <= 1'b0;
            tick_1   <= 1'b0;
            adv      <= 1'b0;
        end else begin
            pre_cnt <= wrap ? '0 : pre_cnt + 1'b1;
            if (wrap) ms_cnt <= second_end ? 10'd0 : ms_cnt + 10'd1;
            tick_1k  <= wrap;
            tick_500 <= wrap && ms_cnt[0];
            tick_4   <= wrap && quarter_end;
            tick_2   <= wrap && half_end;
            tick_1   <= wrap && second_end;
            adv      <= adv_cond;
        end
    end

    always_ff @(posedge CLK_50 or posedge RST) begin
        if (RST)         blink <= 1'b0;
        else if (tick_4) blink <= ~blink;
    end

endmodule

// File: tb/tb_timebase_ctrl.sv
// Bench for timebase_ctrl at CLK_FREQ=4000: directed scenarios plus random
// commands, all checked cycle by cycle against an elapsed-time reference model.
module tb_timebase_ctrl;

    localparam int CLK_FREQ = 4000;
    localparam int P        = CLK_FREQ / 1000;

    logic       CLK_50 = 1'b0;
    logic       RST    = 1'b0;
    logic       start  = 1'b0;
    logic       stop   = 1'b0;
    logic       set    = 1'b0;
    logic       up_key = 1'b0;
    logic       tick_1k, tick_500, tick_4, tick_2, tick_1, adv, blink;
    logic [1:0] state;

    timebase_ctrl #(.CLK_FREQ(CLK_FREQ)) dut (
        .CLK_50(CLK_50), .RST(RST), .start(start), .stop(stop), .set(set),
        .up_key(up_key), .tick_1k(tick_1k), .tick_500(tick_500),
        .tick_4(tick_4), .tick_2(tick_2), .tick_1(tick_1), .adv(adv),
        .blink(blink), .state(state)
    );

    always #5 CLK_50 = ~CLK_50;

    int checks   = 0;
    int failures = 0;

    // Model state: edges elapsed since the last clear, plus registered outputs.
    int phase   = 0;
    int m_state = 0;
    bit m_blink, m_t1k, m_t500, m_t4, m_t2, m_t1, m_adv;

    int cycle       = 0;
    int adv_count   = 0;
    int tick1_count = 0;
    int adv_cycles[$];

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("[TB] FAIL %s at cycle %0d: got 0x%0h expected 0x%0h", tag, cycle, obs, exp);
        end
    endtask

    function automatic logic [8:0] dut_vec();
        return {tick_1k, tick_500, tick_4, tick_2, tick_1, adv, blink, state};
    endfunction

    function automatic logic [8:0] model_vec();
        return {m_t1k, m_t500, m_t4, m_t2, m_t1, m_adv, m_blink, 2'(m_state)};
    endfunction

    task automatic model_reset();
        phase = 0; m_state = 0; m_blink = 0;
        m_t1k = 0; m_t500 = 0; m_t4 = 0; m_t2 = 0; m_t1 = 0; m_adv = 0;
    endtask

    // One rising edge of the reference: the millisecond index is phase/P and a
    // millisecond boundary is the last prescale cycle of each group of P edges.
    task automatic model_edge();
        bit wrap;
        int ms;
        int nxt;
        wrap = (phase % P) == (P - 1);
        ms   = (phase / P) % 1000;
        nxt  = m_state;
        if (stop)                          nxt = 0;
        else if (set)                      nxt = (m_state == 2) ? 1 : 2;
        else if (start && m_state == 0)    nxt = 1;
        m_blink = m_blink ^ m_t4;
        if (nxt == 1 && m_state != 1) begin
            m_t1k = 0; m_t500 = 0; m_t4 = 0; m_t2 = 0; m_t1 = 0; m_adv = 0;
            phase = 0;
        end else begin
            m_t1k  = wrap;
            m_t500 = wrap && (ms % 2 == 1);
            m_t4   = wrap && (ms % 250 == 249);
            m_t2   = wrap && (ms % 500 == 499);
            m_t1   = wrap && (ms == 999);
            if (m_state == 1)      m_adv = m_t1;
            else if (m_state == 2) m_adv = m_t4 && up_key;
            else                   m_adv = 0;
            phase++;
        end
        m_state = nxt;
    endtask

    task automatic applyStimulus(input bit s_start, input bit s_stop, input bit s_set, input bit s_up);
        start = s_start; stop = s_stop; set = s_set; up_key = s_up;
        @(posedge CLK_50);
        model_edge();
        cycle++;
        #1;
        checkOutput("outputs", 32'(dut_vec()), 32'(model_vec()));
        if (adv === 1'b1) begin
            adv_count++;
            adv_cycles.push_back(cycle);
        end
        if (tick_1 === 1'b1) tick1_count++;
        start = 0; stop = 0; set = 0;
    endtask

    task automatic idle(input int n, input bit s_up);
        for (int i = 0; i < n; i++) applyStimulus(0, 0, 0, s_up);
    endtask

    // Asserts RST between edges and expects the outputs to clear without a clock.
    task automatic applyReset();
        #2 RST = 1'b1;
        #1 checkOutput("reset_async", 32'(dut_vec()), 32'd0);
        start = 0; stop = 0; set = 0; up_key = 0;
        model_reset();
        @(negedge CLK_50);
        @(posedge CLK_50);
        #1 checkOutput("reset_held", 32'(dut_vec()), 32'd0);
        @(negedge CLK_50);
        RST = 1'b0;
    endtask

    task automatic measure_first_tick();
        int n;
        n = 0;
        do begin
            applyStimulus(0, 0, 0, 0);
            n++;
        end while (tick_1k !== 1'b1 && n < 20);
        checkOutput("first_tick_1k_delay", n, P);
    endtask

    initial begin
        int base;
        int start_cycle;
        bit up;
        model_reset();

        #1 RST = 1'b1;
        #1 checkOutput("reset_state", 32'(dut_vec()), 32'd0);
        @(negedge CLK_50);
        @(negedge CLK_50);
        RST = 1'b0;
        measure_first_tick();

        // STOP held: tick_1 still runs, adv never fires.
        idle(10000 - P, 0);
        checkOutput("stop_tick1_count", tick1_count, 2);
        checkOutput("stop_adv_count", adv_count, 0);

        // start: state next cycle, adv one second later and every second after.
        adv_cycles.delete();
        applyStimulus(1, 0, 0, 0);
        start_cycle = cycle;
        checkOutput("state_after_start", 32'(state), 32'd1);
        idle(8500, 0);
        checkOutput("run_adv_count", adv_cycles.size(), 2);
        if (adv_cycles.size() >= 2) begin
            checkOutput("first_adv_delay", adv_cycles[0] - start_cycle, 4000);
            checkOutput("adv_period", adv_cycles[1] - adv_cycles[0], 4000);
        end

        // SET: fast advance with up_key, none without, set back to RUN.
        applyStimulus(0, 0, 1, 1);
        checkOutput("state_set", 32'(state), 32'd2);
        base = adv_count;
        idle(3000, 1);
        checkOutput("set_up_adv_count", adv_count - base, 3);
        base = adv_count;
        idle(2000, 0);
        checkOutput("set_noup_adv_count", adv_count - base, 0);
        adv_cycles.delete();
        applyStimulus(0, 0, 1, 0);
        start_cycle = cycle;
        checkOutput("state_set_to_run", 32'(state), 32'd1);
        idle(4100, 0);
        checkOutput("set_run_adv_count", adv_cycles.size(), 1);
        if (adv_cycles.size() >= 1)
            checkOutput("set_run_first_adv", adv_cycles[0] - start_cycle, 4000);

        // All commands together in RUN: stop wins, counters keep going.
        idle(777, 0);
        applyStimulus(1, 1, 1, 0);
        checkOutput("all_cmds_state", 32'(state), 32'd0);
        idle(4500, 0);

        // Random command traffic.
        up = 0;
        for (int i = 0; i < 20000; i++) begin
            if ($urandom_range(0, 299) == 0) up = ~up;
            applyStimulus($urandom_range(0, 1499) == 0, $urandom_range(0, 1999) == 0,
                          $urandom_range(0, 1499) == 0, up);
        end

        // Reset in the middle of a running second.
        applyStimulus(0, 1, 0, 0);
        applyStimulus(1, 0, 0, 0);
        idle(1502, 0);
        applyReset();
        measure_first_tick();
        idle(50, 0);
        checkOutput("post_reset_state", 32'(state), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
